sw_hw_mailbox_ctrl: RTL and testbench

//  Hardware side of the software/hardware PIO mailbox between the Nios II system and game logic.

---
 rtl/sw_hw_mailbox_ctrl.sv | 156 +++++++++++++++
 tb/tb_sw_hw_mailbox_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_hw_mailbox_ctrl.sv
// HW side of the SW/HW PIO mailbox: capture, vsync-aligned commit, status snapshot; MAILBOX_STATS_EN adds counters.
// Response 1 cycle after sampling edge; a write stalls (to_sw_sig=00) while a frame is pending and no frame_tick.
module sw_hw_mailbox_ctrl #(
   parameter int NUM_WORDS      = 16,
   parameter int WORD_W         = 32,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int TO_W           = 20
) (
   input  logic                          clk_clk,
   input  logic                          reset_reset_n,
   input  logic [1:0]                    to_hw_sig,
   input  logic [NUM_WORDS*WORD_W-1:0]   to_hw_words,
   output logic [1:0]                    to_sw_sig,
   input  logic                          frame_tick,
   input  logic [WORD_W-1:0]             hw_status0,
   input  logic [WORD_W-1:0]             hw_status1,
   output logic [WORD_W-1:0]             to_sw_status0,
   output logic [WORD_W-1:0]             to_sw_status1,
   output logic [NUM_WORDS*WORD_W-1:0]   shadow_words,
   output logic                          shadow_valid,
   output logic                          pending_full,
   output logic [15:0]                   stat_frames,
   output logic [15:0]                   stat_errors
);

   // State encoding doubles as the registered response code.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACK_WR = 2'b01,
      ST_STATUS = 2'b10,
      ST_ERROR  = 2'b11
   } state_t;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   state_t                        r_state;
   state_t                        w_state_nxt;
   logic [TO_W-1:0]               r_to_cnt;
   logic [TO_W-1:0]               w_to_nxt;
   logic [NUM_WORDS*WORD_W-1:0]   r_pending;
   logic                          r_pending_full;
   logic [NUM_WORDS*WORD_W-1:0]   r_shadow;
   logic                          r_shadow_valid;
   logic [WORD_W-1:0]             r_status0;
   logic [WORD_W-1:0]             r_status1;
   logic                          w_commit;
   logic                          w_capture;
   logic                          w_snap;
   logic                          w_abort;

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_state  <= ST_IDLE;
         r_to_cnt <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_to_cnt <= w_to_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_to_nxt    = r_to_cnt;
      w_capture   = 1'b0;
      w_snap      = 1'b0;
      w_abort     = 1'b0;
      w_commit    = frame_tick & r_pending_full;
      case (r_state)
         ST_IDLE: begin
            w_to_nxt = '0;
            // A same-edge frame_tick drains the pending slot, so capture may proceed.
            if (to_hw_sig == 2'b01 && (!r_pending_full || frame_tick)) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_ACK_WR;
            end else if (to_hw_sig == 2'b10) begin
               w_snap      = 1'b1;
               w_state_nxt = ST_STATUS;
            end else if (to_hw_sig == 2'b11) begin
               w_abort     = 1'b1;
            end
         end
         ST_ACK_WR, ST_STATUS: begin
            if (to_hw_sig == 2'b00) begin
               w_state_nxt = ST_IDLE;
               w_to_nxt    = '0;
            end else if (r_to_cnt == TO_LAST) begin
               w_state_nxt = ST_ERROR;
               w_to_nxt    = '0;
            end else begin
               w_to_nxt    = r_to_cnt + 1'b1;
            end
         end
         ST_ERROR: begin
            w_to_nxt = '0;
            if (to_hw_sig == 2'b00) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_pending      <= '0;
         r_pending_full <= 1'b0;
         r_shadow       <= '0;
         r_shadow_valid <= 1'b0;
         r_status0      <= '0;
         r_status1      <= '0;
      end else begin
         r_shadow_valid <= w_commit;
         if (w_commit) r_shadow <= r_pending;
         if (w_capture) begin
            r_pending      <= to_hw_words;
            r_pending_full <= 1'b1;
         end else if (w_commit || w_abort) begin
            r_pending_full <= 1'b0;
         end
         if (w_snap) begin
            r_status0 <= hw_status0;
            r_status1 <= hw_status1;
         end
      end
   end

`ifdef MAILBOX_STATS_EN
   logic [15:0] r_stat_frames;
   logic [15:0] r_stat_errors;
   logic        w_err_entry;

   assign w_err_entry = (r_state != ST_ERROR) && (w_state_nxt == ST_ERROR);

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_stat_frames <= '0;
         r_stat_errors <= '0;
      end else begin
         if (w_commit && r_stat_frames != 16'hFFFF) r_stat_frames <= r_stat_frames + 1'b1;
         if (w_err_entry && r_stat_errors != 16'hFFFF) r_stat_errors <= r_stat_errors + 1'b1;
      end
   end

   assign stat_frames = r_stat_frames;
   assign stat_errors = r_stat_errors;
`else
   assign stat_frames = '0;
   assign stat_errors = '0;
`endif

   assign to_sw_sig     = r_state;
   assign to_sw_status0 = r_status0;
   assign to_sw_status1 = r_status1;
   assign shadow_words  = r_shadow;
   assign shadow_valid  = r_shadow_valid;
   assign pending_full  = r_pending_full;

endmodule

// File: tb/tb_sw_hw_mailbox_ctrl.sv
// Bench for sw_hw_mailbox_ctrl: directed vector table, hand sequences (timeout, mid-handshake reset),
// then random traffic checked against a transaction-level mailbox model.
module tb_sw_hw_mailbox_ctrl;
   localparam int NW = 16;
   localparam int WW = 32;
   localparam int TO = 8;
`ifdef MAILBOX_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]       sig = 2'b00;
   logic [NW*WW-1:0] words = '0;
   logic             tick = 1'b0;
   logic [WW-1:0]    st0 = '0;
   logic [WW-1:0]    st1 = '0;
   logic [1:0]       o_sig;
   logic [WW-1:0]    o_s0, o_s1;
   logic [NW*WW-1:0] o_sh;
   logic             o_sv, o_full;
   logic [15:0]      o_sf, o_se;

   int total = 0;
   int bad = 0;

   sw_hw_mailbox_ctrl #(.NUM_WORDS(NW), .WORD_W(WW), .TIMEOUT_CYCLES(TO), .TO_W(4)) dut (
      .clk_clk(clk), .reset_reset_n(rst_n), .to_hw_sig(sig), .to_hw_words(words),
      .to_sw_sig(o_sig), .frame_tick(tick), .hw_status0(st0), .hw_status1(st1),
      .to_sw_status0(o_s0), .to_sw_status1(o_s1), .shadow_words(o_sh),
      .shadow_valid(o_sv), .pending_full(o_full), .stat_frames(o_sf), .stat_errors(o_se)
   );

   // Reference model: the mailbox as a pending slot, a shadow bank and a response code
   int            m_resp, m_age, m_frames, m_errors;
   bit            m_full, m_sv;
   logic [WW-1:0] m_pend[NW];
   logic [WW-1:0] m_shadow[NW];
   logic [WW-1:0] m_s0, m_s1;

   task automatic model_reset();
      m_resp = 0; m_age = 0; m_frames = 0; m_errors = 0;
      m_full = 0; m_sv = 0; m_s0 = '0; m_s1 = '0;
      for (int k = 0; k < NW; k++) begin
         m_pend[k] = '0;
         m_shadow[k] = '0;
      end
   endtask

   task automatic model_edge();
      bit commit, capture;
      commit  = tick && m_full;
      capture = (m_resp == 0) && (sig == 2'd1) && (!m_full || tick);
      m_sv = commit;
      if (commit) begin
         for (int k = 0; k < NW; k++) m_shadow[k] = m_pend[k];
         if (m_frames < 65535) m_frames++;
      end
      if (capture) begin
         for (int k = 0; k < NW; k++) m_pend[k] = words[k*WW +: WW];
         m_full = 1;
      end else if (commit || (m_resp == 0 && sig == 2'd3)) begin
         m_full = 0;
      end
      case (m_resp)
         0: begin
            if (capture) begin
               m_resp = 1; m_age = 0;
            end else if (sig == 2'd2) begin
               m_resp = 2; m_age = 0; m_s0 = st0; m_s1 = st1;
            end
         end
         1, 2: begin
            if (sig == 2'd0) m_resp = 0;
            else if (m_age == TO - 1) begin
               m_resp = 3;
               if (m_errors < 65535) m_errors++;
            end else m_age++;
         end
         default: if (sig == 2'd0) m_resp = 0;
      endcase
   endtask

   function automatic logic [NW*WW-1:0] shadow_vec();
      logic [NW*WW-1:0] r;
      for (int k = 0; k < NW; k++) r[k*WW +: WW] = m_shadow[k];
      return r;
   endfunction

   function automatic logic [NW*WW-1:0] make_words(input logic [WW-1:0] w0);
      logic [NW*WW-1:0] r;
      for (int k = 0; k < NW; k++) r[k*WW +: WW] = w0 + WW'(k);
      return r;
   endfunction

   task automatic chk(input string nm, input logic [NW*WW-1:0] act, input logic [NW*WW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, "_sig"},  o_sig,  m_resp[1:0]);
      chk({tag, "_full"}, o_full, m_full);
      chk({tag, "_sv"},   o_sv,   m_sv);
      chk({tag, "_sh"},   o_sh,   shadow_vec());
      chk({tag, "_s0"},   o_s0,   m_s0);
      chk({tag, "_s1"},   o_s1,   m_s1);
      chk({tag, "_sf"},   o_sf,   STATS ? m_frames[15:0] : 16'd0);
      chk({tag, "_se"},   o_se,   STATS ? m_errors[15:0] : 16'd0);
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [1:0]  sig;
      logic        tick;
      logic [31:0] w0;
      logic [31:0] s0;
      logic [1:0]  e_sig;
      logic        e_full;
      logic        e_sv;
      logic [31:0] e_sh0;
      logic [31:0] e_st0;
   } vec_t;

   vec_t tbl[20];

   initial begin
      tbl[0]  = '{2'd1, 1'b0, 32'hDEAD_BEEF, 32'h0,   2'd1, 1'b1, 1'b0, 32'h0,         32'h0};
      tbl[1]  = '{2'd0, 1'b0, 32'hDEAD_BEEF, 32'h0,   2'd0, 1'b1, 1'b0, 32'h0,         32'h0};
      tbl[2]  = '{2'd0, 1'b1, 32'hDEAD_BEEF, 32'h0,   2'd0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0};
      tbl[3]  = '{2'd0, 1'b0, 32'hDEAD_BEEF, 32'h0,   2'd0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0};
      tbl[4]  = '{2'd1, 1'b0, 32'h1111_1111, 32'h0,   2'd1, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0};
      tbl[5]  = '{2'd0, 1'b0, 32'h1111_1111, 32'h0,   2'd0, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0};
      tbl[6]  = '{2'd1, 1'b0, 32'h2222_2222, 32'h0,   2'd0, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0};
      tbl[7]  = '{2'd1, 1'b1, 32'h2222_2222, 32'h0,   2'd1, 1'b1, 1'b1, 32'h1111_1111, 32'h0};
      tbl[8]  = '{2'd0, 1'b0, 32'h2222_2222, 32'h0,   2'd0, 1'b1, 1'b0, 32'h1111_1111, 32'h0};
      tbl[9]  = '{2'd0, 1'b1, 32'h2222_2222, 32'h0,   2'd0, 1'b0, 1'b1, 32'h2222_2222, 32'h0};
      tbl[10] = '{2'd2, 1'b0, 32'h0,         32'h123, 2'd2, 1'b0, 1'b0, 32'h2222_2222, 32'h123};
      tbl[11] = '{2'd2, 1'b0, 32'h0,         32'h456, 2'd2, 1'b0, 1'b0, 32'h2222_2222, 32'h123};
      tbl[12] = '{2'd0, 1'b0, 32'h0,         32'h456, 2'd0, 1'b0, 1'b0, 32'h2222_2222, 32'h123};
      tbl[13] = '{2'd2, 1'b0, 32'h0,         32'h456, 2'd2, 1'b0, 1'b0, 32'h2222_2222, 32'h456};
      tbl[14] = '{2'd0, 1'b0, 32'h0,         32'h456, 2'd0, 1'b0, 1'b0, 32'h2222_2222, 32'h456};
      tbl[15] = '{2'd1, 1'b0, 32'h3333_3333, 32'h456, 2'd1, 1'b1, 1'b0, 32'h2222_2222, 32'h456};
      tbl[16] = '{2'd0, 1'b0, 32'h3333_3333, 32'h456, 2'd0, 1'b1, 1'b0, 32'h2222_2222, 32'h456};
      tbl[17] = '{2'd3, 1'b0, 32'h3333_3333, 32'h456, 2'd0, 1'b0, 1'b0, 32'h2222_2222, 32'h456};
      tbl[18] = '{2'd0, 1'b1, 32'h3333_3333, 32'h456, 2'd0, 1'b0, 1'b0, 32'h2222_2222, 32'h456};
      tbl[19] = '{2'd0, 1'b0, 32'h3333_3333, 32'h456, 2'd0, 1'b0, 1'b0, 32'h2222_2222, 32'h456};

      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_model("reset");
      @(negedge clk);
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 20; i++) begin
         sig   = tbl[i].sig;
         tick  = tbl[i].tick;
         words = make_words(tbl[i].w0);
         st0   = tbl[i].s0;
         step();
         chk($sformatf("v%0d_sig", i),  o_sig,  tbl[i].e_sig);
         chk($sformatf("v%0d_full", i), o_full, tbl[i].e_full);
         chk($sformatf("v%0d_sv", i),   o_sv,   tbl[i].e_sv);
         chk($sformatf("v%0d_sh0", i),  o_sh[WW-1:0], tbl[i].e_sh0);
         chk($sformatf("v%0d_st0", i),  o_s0,   tbl[i].e_st0);
      end
      tick = 1'b0;

      // Held write request: acknowledged for TO cycles, then error until released
      sig   = 2'd1;
      words = make_words(32'hA5A5_0000);
      for (int i = 0; i < TO; i++) begin
         step();
         chk($sformatf("to_ack%0d", i), o_sig, 2'd1);
      end
      step();
      chk("to_err", o_sig, 2'd3);
      step();
      chk("to_err_hold", o_sig, 2'd3);
      chk("to_keep_pend", o_full, 1'b1);
      sig = 2'd0;
      step();
      chk("to_release", o_sig, 2'd0);
      chk("to_stat_err", o_se, STATS ? 16'd1 : 16'd0);
      chk("to_stat_frm", o_sf, STATS ? 16'd3 : 16'd0);

      // Asynchronous reset in the middle of a write handshake
      tick = 1'b1;
      step();
      chk("pre_rst_commit", o_sh[WW-1:0], 32'hA5A5_0000);
      tick  = 1'b0;
      sig   = 2'd1;
      words = make_words(32'hB0B0_0000);
      step();
      chk("pre_rst_ack", o_sig, 2'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_sig", o_sig, 2'd0);
      chk("rst_full", o_full, 1'b0);
      chk("rst_sh", o_sh, '0);
      chk("rst_s0", o_s0, 32'h0);
      chk("rst_sf", o_sf, 16'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      words = make_words(32'hC0C0_0000);
      step();
      chk("post_rst_ack", o_sig, 2'd1);
      chk("post_rst_full", o_full, 1'b1);
      sig = 2'd0;
      step();
      chk("post_rst_idle", o_sig, 2'd0);
      tick = 1'b1;
      step();
      chk("post_rst_sv", o_sv, 1'b1);
      chk("post_rst_sh0", o_sh[WW-1:0], 32'hC0C0_0000);
      chk_model("post_rst");
      tick = 1'b0;

      // Random traffic against the model
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 2) == 0) sig = 2'($urandom_range(0, 3));
         tick = ($urandom_range(0, 4) == 0);
         for (int k = 0; k < NW; k++) words[k*WW +: WW] = $urandom;
         st0 = $urandom;
         st1 = $urandom;
         step();
         chk_model($sformatf("rnd%0d", c));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
